barrel_track_engine: RTL and testbench



---
 rtl/barrel_pkg.sv | 30 +++
 rtl/barrel_channel.sv | 102 ++++++++++
 rtl/barrel_track_engine.sv | 117 +++++++++++
 tb/tb_barrel_track_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared channel state encoding and girder track geometry for the barrel engine.
// Rows alternate direction: even rows roll left, odd rows roll right.
package barrel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ROLL_LEFT  = 2'd1,
    ST_ROLL_RIGHT = 2'd2,
    ST_FALL       = 2'd3
  } chan_state_t;

  localparam int         NUM_ROWS = 5;
  localparam logic [2:0] LAST_ROW = 3'd4;
  localparam logic [6:0] ROW_Y [NUM_ROWS] = '{7'd16, 7'd40, 7'd64, 7'd88, 7'd113};

  function automatic logic [6:0] row_y(input logic [2:0] row);
    case (row)
      3'd0:    return ROW_Y[0];
      3'd1:    return ROW_Y[1];
      3'd2:    return ROW_Y[2];
      3'd3:    return ROW_Y[3];
      default: return ROW_Y[4];
    endcase
  endfunction

  function automatic chan_state_t row_dir(input logic [2:0] row);
    return row[0] ? ST_ROLL_RIGHT : ST_ROLL_LEFT;
  endfunction

endpackage

// File: rtl/barrel_channel.sv
// One barrel: spawn, roll, fall and despawn along the track, advancing one pixel per Tick.
// Overlap is combinational against the registered position; the top registers the OR.
module barrel_channel
  import barrel_pkg::*;
#(
  parameter int SPAWN_X  = 133,
  parameter int MAX_X    = 155,
  parameter int BARREL_W = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Spawn,
  input  logic [7:0] PlayerX,
  input  logic [6:0] PlayerY,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic       Active,
  output logic       Idle,
  output logic       Despawning,
  output logic       Overlap
);

  localparam logic [7:0] L_SPAWN_X = 8'(SPAWN_X);
  localparam logic [7:0] L_MAX_X   = 8'(MAX_X);
  localparam logic [8:0] L_W       = 9'(BARREL_W);

  chan_state_t r_state;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_row;
  logic [2:0]  w_next_row;
  logic [6:0]  w_y_inc;
  logic [8:0]  w_dx;
  logic [8:0]  w_dy;

  assign w_next_row = r_row + 3'd1;
  assign w_y_inc    = r_y + 7'd1;

  // The move that lands on a row end also switches to FALL, so every tick moves one pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_row   <= '0;
    end else if (Tick) begin
      case (r_state)
        ST_IDLE: begin
          if (Spawn) begin
            r_state <= ST_ROLL_LEFT;
            r_x     <= L_SPAWN_X;
            r_y     <= ROW_Y[0];
            r_row   <= '0;
          end
        end
        ST_ROLL_LEFT: begin
          if (r_x != 8'd0) begin
            r_x <= r_x - 8'd1;
            if (r_x == 8'd1 && r_row != LAST_ROW) r_state <= ST_FALL;
          end else if (r_row != LAST_ROW) begin
            r_state <= ST_FALL;
          end else begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_row   <= '0;
          end
        end
        ST_ROLL_RIGHT: begin
          if (r_x < L_MAX_X) begin
            r_x <= r_x + 8'd1;
            if (r_x == L_MAX_X - 8'd1) r_state <= ST_FALL;
          end else begin
            r_state <= ST_FALL;
          end
        end
        ST_FALL: begin
          r_y <= w_y_inc;
          if (w_y_inc == row_y(w_next_row)) begin
            r_row   <= w_next_row;
            r_state <= row_dir(w_next_row);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign X          = r_x;
  assign Y          = r_y;
  assign Active     = (r_state != ST_IDLE);
  assign Idle       = (r_state == ST_IDLE);
  assign Despawning = Tick && (r_state == ST_ROLL_LEFT) && (r_x == 8'd0) && (r_row == LAST_ROW);

  assign w_dx = (r_x >= PlayerX) ? ({1'b0, r_x} - {1'b0, PlayerX})
                                 : ({1'b0, PlayerX} - {1'b0, r_x});
  assign w_dy = (r_y >= PlayerY) ? ({2'b00, r_y} - {2'b00, PlayerY})
                                 : ({2'b00, PlayerY} - {2'b00, r_y});

  assign Overlap = Active && (w_dx < L_W) && (w_dy < L_W);

endmodule

// File: rtl/barrel_track_engine.sv
// Multi-barrel engine: tick divider, spawn timer, lowest-index-idle arbiter and registered Hit.
// Enable=0 freezes the divider and therefore all motion; collision keeps evaluating.
module barrel_track_engine
  import barrel_pkg::*;
#(
  parameter int N_BARRELS   = 4,
  parameter int TICK_DIV    = 1562500,
  parameter int SPAWN_TICKS = 96,
  parameter int SPAWN_X     = 133,
  parameter int MAX_X       = 155,
  parameter int BARREL_W    = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic [7:0]             PlayerX,
  input  logic [6:0]             PlayerY,
  output logic [8*N_BARRELS-1:0] BarrelX,
  output logic [7*N_BARRELS-1:0] BarrelY,
  output logic [N_BARRELS-1:0]   BarrelActive,
  output logic                   Tick,
  output logic                   SpawnMiss,
  output logic                   Hit
);

  localparam int            TW          = $clog2(TICK_DIV + 1);
  localparam int            SW          = $clog2(SPAWN_TICKS + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST  = SW'(SPAWN_TICKS - 1);

  logic [TW-1:0]        r_tick_cnt;
  logic [SW-1:0]        r_spawn_cnt;
  logic                 r_tick;
  logic                 r_spawn_due;
  logic                 r_spawn_miss;
  logic                 r_hit;
  logic                 w_tick_due;
  logic                 w_spawn_now;
  logic                 w_any_free;
  logic [N_BARRELS-1:0] w_idle;
  logic [N_BARRELS-1:0] w_despawn;
  logic [N_BARRELS-1:0] w_overlap;
  logic [N_BARRELS-1:0] w_eligible;
  logic [N_BARRELS-1:0] w_grant;

  assign w_tick_due  = Enable && (r_tick_cnt == '0);
  assign w_spawn_now = w_tick_due && (r_spawn_cnt == SPAWN_LAST);

  // Spawn/miss are decided on the cycle the tick is due; channels only change on r_tick,
  // so the idle set seen here is exactly the pre-tick set the channels act on.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tick_cnt   <= TICK_RELOAD;
      r_spawn_cnt  <= '0;
      r_tick       <= 1'b0;
      r_spawn_due  <= 1'b0;
      r_spawn_miss <= 1'b0;
      r_hit        <= 1'b0;
    end else begin
      r_tick       <= w_tick_due;
      r_spawn_due  <= w_spawn_now;
      r_spawn_miss <= w_spawn_now && !w_any_free;
      r_hit        <= |w_overlap;
      if (w_tick_due) begin
        r_tick_cnt  <= TICK_RELOAD;
        r_spawn_cnt <= w_spawn_now ? '0 : r_spawn_cnt + SW'(1);
      end else if (Enable) begin
        r_tick_cnt <= r_tick_cnt - TW'(1);
      end
    end
  end

  assign w_eligible = w_idle & ~w_despawn;

  always_comb begin
    w_grant    = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < N_BARRELS; i++) begin
      if (w_eligible[i] && !w_any_free) begin
        w_grant[i] = 1'b1;
        w_any_free = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_BARRELS; gi++) begin : g_chan
    logic [7:0] w_x;
    logic [6:0] w_y;

    barrel_channel #(
      .SPAWN_X  (SPAWN_X),
      .MAX_X    (MAX_X),
      .BARREL_W (BARREL_W)
    ) u_chan (
      .Clk        (Clk),
      .Reset      (Reset),
      .Tick       (r_tick),
      .Spawn      (r_spawn_due && w_grant[gi]),
      .PlayerX    (PlayerX),
      .PlayerY    (PlayerY),
      .X          (w_x),
      .Y          (w_y),
      .Active     (BarrelActive[gi]),
      .Idle       (w_idle[gi]),
      .Despawning (w_despawn[gi]),
      .Overlap    (w_overlap[gi])
    );

    assign BarrelX[8*gi +: 8] = w_x;
    assign BarrelY[7*gi +: 7] = w_y;
  end

  assign Tick      = r_tick;
  assign SpawnMiss = r_spawn_miss;
  assign Hit       = r_hit;

endmodule

// File: tb/tb_barrel_track_engine.sv
// Bench for barrel_track_engine: a short-period instance for spawn/miss/hold/reset/collision
// and a long-period instance that follows one barrel over the whole track.
`timescale 1ns/1ps
module tb_barrel_track_engine;

  logic Clk = 1'b0;
  initial forever #5 Clk = ~Clk;

  logic        rst_a, en_a, tick_a, miss_a, hit_a;
  logic [7:0]  px_a;
  logic [6:0]  py_a;
  logic [15:0] bx_a;
  logic [13:0] by_a;
  logic [1:0]  act_a;

  logic        rst_b, en_b, tick_b, miss_b, hit_b;
  logic [7:0]  px_b;
  logic [6:0]  py_b;
  logic [15:0] bx_b;
  logic [13:0] by_b;
  logic [1:0]  act_b;

  barrel_track_engine #(.N_BARRELS(2), .TICK_DIV(4), .SPAWN_TICKS(8)) dut (
    .Clk(Clk), .Reset(rst_a), .Enable(en_a), .PlayerX(px_a), .PlayerY(py_a),
    .BarrelX(bx_a), .BarrelY(by_a), .BarrelActive(act_a),
    .Tick(tick_a), .SpawnMiss(miss_a), .Hit(hit_a));

  barrel_track_engine #(.N_BARRELS(2), .TICK_DIV(4), .SPAWN_TICKS(1000)) dut_long (
    .Clk(Clk), .Reset(rst_b), .Enable(en_b), .PlayerX(px_b), .PlayerY(py_b),
    .BarrelX(bx_b), .BarrelY(by_b), .BarrelActive(act_b),
    .Tick(tick_b), .SpawnMiss(miss_b), .Hit(hit_b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] px;
    logic [6:0] py;
    logic       hit;
  } hvec_t;

  typedef struct {
    int dx;
    int dy;
    int n;
  } seg_t;

  hvec_t hv [13];
  seg_t  segs [9];
  logic  exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick_a(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!tick_a && n < 200);
    if (!tick_a) begin
      checks++;
      errors++;
      $display("FAIL tick_a_timeout: got no Tick, expected one within 200 cycles");
    end
  endtask

  task automatic wait_tick_b(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!tick_b && n < 200);
    if (!tick_b) begin
      checks++;
      errors++;
      $display("FAIL tick_b_timeout: got no Tick, expected one within 200 cycles");
    end
  endtask

  task automatic run_short();
    int n;
    logic saw, moved, missed;
    hv[0]  = '{8'd130, 7'd16, 1'b1};
    hv[1]  = '{8'd127, 7'd16, 1'b0};
    hv[2]  = '{8'd128, 7'd16, 1'b0};
    hv[3]  = '{8'd129, 7'd16, 1'b1};
    hv[4]  = '{8'd137, 7'd16, 1'b1};
    hv[5]  = '{8'd138, 7'd16, 1'b0};
    hv[6]  = '{8'd133, 7'd20, 1'b1};
    hv[7]  = '{8'd133, 7'd21, 1'b0};
    hv[8]  = '{8'd133, 7'd12, 1'b1};
    hv[9]  = '{8'd133, 7'd11, 1'b0};
    hv[10] = '{8'd0,   7'd0,  1'b0};
    hv[11] = '{8'd255, 7'd127, 1'b0};
    hv[12] = '{8'd137, 7'd20, 1'b1};

    rst_a = 1'b1; en_a = 1'b1; px_a = 8'd0; py_a = 7'd100;
    repeat (2) @(negedge Clk);
    chk("rst_active", int'(act_a), 0);
    chk("rst_x", int'(bx_a), 0);
    chk("rst_y", int'(by_a), 0);
    chk("rst_tick", int'(tick_a), 0);
    chk("rst_miss", int'(miss_a), 0);
    chk("rst_hit", int'(hit_a), 0);
    rst_a = 1'b0;

    wait_tick_a(n);
    wait_tick_a(n);
    chk("tick_period", n, 4);
    for (int t = 3; t <= 7; t++) wait_tick_a(n);
    @(negedge Clk);
    chk("no_spawn_before_t8", int'(act_a), 0);
    wait_tick_a(n);
    chk("miss_t8", int'(miss_a), 0);
    @(negedge Clk);
    chk("spawn_active", int'(act_a), 1);
    chk("spawn_x", int'(bx_a[7:0]), 133);
    chk("spawn_y", int'(by_a[6:0]), 16);

    // Freeze motion with the barrel parked at (133,16) and sweep the collision window.
    en_a = 1'b0;
    for (int i = 0; i < 13; i++) begin
      px_a = hv[i].px;
      py_a = hv[i].py;
      exp_q.push_back(hv[i].hit);
      @(negedge Clk);
      chk($sformatf("hit_vec%0d", i), int'(hit_a), int'(exp_q.pop_front()));
    end

    px_a = 8'd0; py_a = 7'd100;
    saw = 1'b0; moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (tick_a) saw = 1'b1;
      if (bx_a[7:0] != 8'd133 || by_a[6:0] != 7'd16) moved = 1'b1;
    end
    chk("hold_no_tick", int'(saw), 0);
    chk("hold_pos", int'(moved), 0);
    en_a = 1'b1;
    wait_tick_a(n);
    chk("resume_latency", n, 3);
    @(negedge Clk);
    chk("t9_x", int'(bx_a[7:0]), 132);
    chk("t9_y", int'(by_a[6:0]), 16);

    missed = 1'b0;
    for (int t = 10; t <= 16; t++) begin
      wait_tick_a(n);
      if (miss_a) missed = 1'b1;
    end
    @(negedge Clk);
    chk("two_active", int'(act_a), 3);
    chk("ch1_spawn_x", int'(bx_a[15:8]), 133);
    chk("ch0_x_t16", int'(bx_a[7:0]), 125);
    for (int t = 17; t <= 23; t++) begin
      wait_tick_a(n);
      if (miss_a) missed = 1'b1;
    end
    chk("no_early_miss", int'(missed), 0);
    wait_tick_a(n);
    chk("miss_t24", int'(miss_a), 1);
    @(negedge Clk);
    chk("miss_one_cycle", int'(miss_a), 0);
    chk("miss_no_spawn", int'(act_a), 3);
    chk("ch0_x_t24", int'(bx_a[7:0]), 117);

    for (int t = 25; t <= 145; t++) wait_tick_a(n);
    @(negedge Clk);
    chk("fall_x_t145", int'(bx_a[7:0]), 0);
    chk("fall_y_t145", int'(by_a[6:0]), 20);
    chk("ch1_x_t145", int'(bx_a[15:8]), 4);
    px_a = 8'd0; py_a = 7'd24;
    exp_q.push_back(1'b1);
    @(negedge Clk);
    chk("hit_falling", int'(hit_a), int'(exp_q.pop_front()));

    rst_a = 1'b1;
    @(negedge Clk);
    chk("midfall_rst_active", int'(act_a), 0);
    chk("midfall_rst_x", int'(bx_a), 0);
    chk("midfall_rst_y", int'(by_a), 0);
    chk("midfall_rst_hit", int'(hit_a), 0);
    chk("midfall_rst_tick", int'(tick_a), 0);
    rst_a = 1'b0;
    px_a = 8'd0; py_a = 7'd100;
    for (int t = 1; t <= 7; t++) wait_tick_a(n);
    @(negedge Clk);
    chk("rerst_no_spawn_t7", int'(act_a), 0);
    wait_tick_a(n);
    @(negedge Clk);
    chk("rerst_spawn_active", int'(act_a), 1);
    chk("rerst_spawn_x", int'(bx_a[7:0]), 133);
  endtask

  task automatic run_long();
    int n, cnt, ex, ey;
    segs[0] = '{-1, 0, 133};
    segs[1] = '{ 0, 1, 24};
    segs[2] = '{ 1, 0, 155};
    segs[3] = '{ 0, 1, 24};
    segs[4] = '{-1, 0, 155};
    segs[5] = '{ 0, 1, 24};
    segs[6] = '{ 1, 0, 155};
    segs[7] = '{ 0, 1, 25};
    segs[8] = '{-1, 0, 155};

    rst_b = 1'b1; en_b = 1'b1; px_b = 8'd200; py_b = 7'd0;
    repeat (2) @(negedge Clk);
    rst_b = 1'b0;
    cnt = 0; n = 0;
    while (!act_b[0] && n < 5000) begin
      @(negedge Clk);
      n++;
      if (tick_b) cnt++;
    end
    chk("long_spawn_tick", cnt, 1000);
    chk("long_spawn_x", int'(bx_b[7:0]), 133);
    chk("long_spawn_y", int'(by_b[6:0]), 16);
    ex = 133; ey = 16;
    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < segs[s].n; k++) begin
        wait_tick_b(n);
        @(negedge Clk);
        ex += segs[s].dx;
        ey += segs[s].dy;
        chk($sformatf("long_pos_seg%0d_step%0d", s, k),
            int'(bx_b[7:0]) * 256 + int'(by_b[6:0]), ex * 256 + ey);
      end
    end
    chk("long_active_at_end", int'(act_b), 1);
    wait_tick_b(n);
    @(negedge Clk);
    chk("long_despawn", int'(act_b), 0);
  endtask

  initial begin
    fork
      run_short();
      run_long();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected completion by 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
